// File: rtl/event_quota_detector_pkg.sv
// Shared types for the event quota detector.
// FSM state encoding used by the top and debug.
package event_quota_detector_pkg;

  typedef enum logic [1:0] {
    Q_ARMED = 2'd0,
    Q_DONE  = 2'd1,
    Q_HOLD  = 2'd2
  } q_state_t;

  localparam int Q_STATE_W = 2;

endpackage

// File: rtl/event_quota_detector_channel.sv
// One event channel: edge detect, saturating counter,
// met compare and sticky overflow flag.
module quota_channel #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             ev,
  input  logic [CNT_W-1:0] target,
  input  logic             armed,
  input  logic             reload,
  output logic [CNT_W-1:0] count,
  output logic             met,
  output logic             overflow
);

  logic prev_ev;
  logic ev_edge;

  assign ev_edge = ev & ~prev_ev;
  assign met     = (count >= target);

  // prev_ev ignores clear so a held input is not recounted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ev  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      prev_ev <= ev;
      if (clear) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (reload) begin
        count <= CNT_W'(ev_edge);
      end else if (ev_edge) begin
        if (armed && !met) begin
          count <= count + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/event_quota_detector.sv
// N-channel event quota detector: per-channel counters
// plus a completion FSM (sticky or auto-restart).
module event_quota_detector
  import event_quota_detector_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 3,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       ev_in,
  input  logic [NUM_CH*CNT_W-1:0] target,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       ch_met,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    done,
  output logic                    done_pulse,
  output logic [Q_STATE_W-1:0]    state
);

  q_state_t          st_q;
  q_state_t          st_d;
  logic [NUM_CH-1:0] ev_q;
  logic              seen_q;
  logic              any_edge;
  logic              armed;
  logic              reload;

  assign any_edge = |(ev_in & ~ev_q);
  assign armed    = (st_q == Q_ARMED);
  assign reload   = (st_q == Q_DONE) && AUTO_RESTART;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quota_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .ev      (ev_in[g]),
      .target  (target[g*CNT_W +: CNT_W]),
      .armed   (armed),
      .reload  (reload),
      .count   (count[g*CNT_W +: CNT_W]),
      .met     (ch_met[g]),
      .overflow(overflow[g])
    );
  end

  // seen_q keeps all-zero targets from completing
  // before any event has been observed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= Q_ARMED;
      ev_q   <= '0;
      seen_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ev_q <= ev_in;
      if (clear) begin
        seen_q <= 1'b0;
      end else if (any_edge) begin
        seen_q <= 1'b1;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      Q_ARMED: begin
        if ((&ch_met) && seen_q) begin
          st_d = Q_DONE;
        end
      end
      Q_DONE: begin
        st_d = AUTO_RESTART ? Q_ARMED : Q_HOLD;
      end
      Q_HOLD: begin
        st_d = Q_HOLD;
      end
      default: begin
        st_d = Q_ARMED;
      end
    endcase
    if (clear) begin
      st_d = Q_ARMED;
    end
  end

  assign done       = (st_q == Q_DONE) || (st_q == Q_HOLD);
  assign done_pulse = (st_q == Q_DONE);
  assign state      = st_q;

endmodule

// File: tb/tb_event_quota_detector.sv
// Randomised scoreboard bench for event_quota_detector,
// running a sticky and an auto-restart instance side by side.
module tb_event_quota_detector;

  localparam int NCH = 2;
  localparam int CW  = 3;
  localparam int TW  = NCH * CW;

  typedef struct {
    logic [TW-1:0]  count;
    logic [NCH-1:0] met;
    logic [NCH-1:0] ovf;
    logic [1:0]     st;
    logic           done;
    logic           pulse;
  } exp_t;

  typedef struct {
    exp_t e0;
    exp_t e1;
  } exp_pair_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clear = 1'b0;
  logic [NCH-1:0] ev_in = '0;
  logic [TW-1:0]  target = '0;

  logic [TW-1:0]  count_s, count_a;
  logic [NCH-1:0] met_s, met_a, ovf_s, ovf_a;
  logic           done_s, done_a, pulse_s, pulse_a;
  logic [1:0]     state_s, state_a;

  int n_cmp = 0;
  int n_err = 0;

  exp_pair_t sbq[$];

  // abstract reference: per mode counts, flags, phase
  int cnt[2][NCH];
  bit ovf[2][NCH];
  int ph[2];
  bit seen[2];
  bit prev[NCH];

  always #5 clk = ~clk;

  event_quota_detector #(
    .NUM_CH(NCH), .CNT_W(CW), .AUTO_RESTART(1'b0)
  ) u_sticky (
    .clk(clk), .reset(reset), .clear(clear),
    .ev_in(ev_in), .target(target),
    .count(count_s), .ch_met(met_s),
    .overflow(ovf_s), .done(done_s),
    .done_pulse(pulse_s), .state(state_s)
  );

  event_quota_detector #(
    .NUM_CH(NCH), .CNT_W(CW), .AUTO_RESTART(1'b1)
  ) u_auto (
    .clk(clk), .reset(reset), .clear(clear),
    .ev_in(ev_in), .target(target),
    .count(count_a), .ch_met(met_a),
    .overflow(ovf_a), .done(done_a),
    .done_pulse(pulse_a), .state(state_a)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic int tgt_of(input logic [TW-1:0] tg,
                                input int i);
    logic [TW-1:0] t;
    t = tg >> (i * CW);
    return int'(t[CW-1:0]);
  endfunction

  function automatic exp_t snap(input int m,
                                input logic [TW-1:0] tg);
    exp_t e;
    e.count = '0;
    e.met   = '0;
    e.ovf   = '0;
    for (int i = 0; i < NCH; i++) begin
      e.count[i*CW +: CW] = CW'(cnt[m][i]);
      e.met[i] = (cnt[m][i] >= tgt_of(tg, i));
      e.ovf[i] = ovf[m][i];
    end
    e.st    = 2'(ph[m]);
    e.done  = (ph[m] != 0);
    e.pulse = (ph[m] == 1);
    return e;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[m][i] = 0;
        ovf[m][i] = 1'b0;
      end
      ph[m]   = 0;
      seen[m] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) prev[i] = 1'b0;
  endtask

  // phases: 0 waiting, 1 completion cycle, 2 holding
  task automatic model_clock(input logic [NCH-1:0] ev,
                             input logic [TW-1:0] tg,
                             input bit clr);
    bit ed[NCH];
    bit any;
    bit all_met;
    any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ed[i] = ev[i] && !prev[i];
      any   = any | ed[i];
    end
    for (int m = 0; m < 2; m++) begin
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          cnt[m][i] = 0;
          ovf[m][i] = 1'b0;
        end
        ph[m]   = 0;
        seen[m] = 1'b0;
      end else begin
        all_met = 1'b1;
        for (int i = 0; i < NCH; i++)
          if (cnt[m][i] < tgt_of(tg, i)) all_met = 1'b0;
        if (ph[m] == 0) begin
          for (int i = 0; i < NCH; i++) begin
            if (ed[i] && cnt[m][i] < tgt_of(tg, i))
              cnt[m][i]++;
            else if (ed[i])
              ovf[m][i] = 1'b1;
          end
          if (all_met && seen[m]) ph[m] = 1;
        end else if (ph[m] == 1 && m == 1) begin
          for (int i = 0; i < NCH; i++)
            cnt[m][i] = ed[i] ? 1 : 0;
          ph[m] = 0;
        end else begin
          for (int i = 0; i < NCH; i++)
            if (ed[i]) ovf[m][i] = 1'b1;
          ph[m] = 2;
        end
        if (any) seen[m] = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) prev[i] = ev[i];
  endtask

  task automatic step(input logic [NCH-1:0] ev,
                      input logic [TW-1:0] tg,
                      input bit clr,
                      input bit rst);
    exp_pair_t p;
    @(negedge clk);
    ev_in  = ev;
    target = tg;
    clear  = clr;
    if (rst) begin
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      p.e0 = snap(0, tg);
      chk("async_cnt", 32'(count_s), 32'(p.e0.count));
      chk("async_ovf", 32'(ovf_a), 32'(p.e0.ovf));
      chk("async_st", 32'(state_a), 32'(p.e0.st));
      chk("async_done", 32'(done_s), 32'(p.e0.done));
      chk("async_pls", 32'(pulse_a), 32'(p.e0.pulse));
    end else begin
      reset = 1'b0;
      model_clock(ev, tg, clr);
    end
    p.e0 = snap(0, tg);
    p.e1 = snap(1, tg);
    sbq.push_back(p);
  endtask

  task automatic cmp_one(input string md, input exp_t e,
                         input logic [TW-1:0] c,
                         input logic [NCH-1:0] mt,
                         input logic [NCH-1:0] ov,
                         input logic [1:0] s,
                         input logic d, input logic pl);
    chk({md, "_count"}, 32'(c), 32'(e.count));
    chk({md, "_ch_met"}, 32'(mt), 32'(e.met));
    chk({md, "_overflow"}, 32'(ov), 32'(e.ovf));
    chk({md, "_state"}, 32'(s), 32'(e.st));
    chk({md, "_done"}, 32'(d), 32'(e.done));
    chk({md, "_done_pulse"}, 32'(pl), 32'(e.pulse));
  endtask

  initial begin : monitor
    exp_pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        p = sbq.pop_front();
        cmp_one("sticky", p.e0, count_s, met_s, ovf_s,
                state_s, done_s, pulse_s);
        cmp_one("auto", p.e1, count_a, met_a, ovf_a,
                state_a, done_a, pulse_a);
      end
    end
  end

  initial begin : driver
    logic [TW-1:0]  tg;
    logic [NCH-1:0] ev;
    model_reset();
    step(2'b00, 6'o22, 1'b0, 1'b1);
    // sequential pulses, targets 2/2
    step(2'b01, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b10, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b01, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b10, 6'o22, 1'b0, 1'b0);
    repeat (4) step(2'b00, 6'o22, 1'b0, 1'b0);
    // simultaneous edges
    step(2'b00, 6'o22, 1'b1, 1'b0);
    step(2'b11, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b11, 6'o22, 1'b0, 1'b0);
    repeat (3) step(2'b00, 6'o22, 1'b0, 1'b0);
    // held level, then overflow
    step(2'b00, 6'o22, 1'b1, 1'b0);
    repeat (10) step(2'b01, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b01, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b01, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    // targets 1/1, edge in the completion cycle
    step(2'b00, 6'o11, 1'b1, 1'b0);
    step(2'b11, 6'o11, 1'b0, 1'b0);
    step(2'b00, 6'o11, 1'b0, 1'b0);
    step(2'b01, 6'o11, 1'b0, 1'b0);
    repeat (3) step(2'b00, 6'o11, 1'b0, 1'b0);
    // clear from hold, then async reset mid-count
    step(2'b00, 6'o22, 1'b1, 1'b0);
    step(2'b11, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b0);
    step(2'b00, 6'o22, 1'b0, 1'b1);
    // targets 0/3, lower target 1 while count 1
    step(2'b00, 6'o30, 1'b0, 1'b0);
    step(2'b10, 6'o30, 1'b0, 1'b0);
    step(2'b00, 6'o30, 1'b0, 1'b0);
    step(2'b00, 6'o10, 1'b0, 1'b0);
    repeat (3) step(2'b00, 6'o10, 1'b0, 1'b0);
    // all targets zero after reset
    step(2'b00, 6'o00, 1'b0, 1'b1);
    repeat (2) step(2'b00, 6'o00, 1'b0, 1'b0);
    step(2'b01, 6'o00, 1'b0, 1'b0);
    repeat (5) step(2'b00, 6'o00, 1'b0, 1'b0);
    // randomised traffic
    tg = 6'o21;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0)
        tg = TW'($urandom_range(0, (1 << TW) - 1));
      ev = NCH'($urandom_range(0, (1 << NCH) - 1));
      step(ev, tg,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 199) == 0);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
